io_bridge: RTL and testbench
============================

Name: io_bridge

Overview:
- Memory-mapped I/O bridge downstream of the core's data-memory port (ALU result as address, rD2 as write data, dram_we as write strobe).
- Decodes each access to either the data RAM or a peripheral page: LEDs, switches and an 8-digit seven-segment display.
- Owns the LED register, the display register, the switch synchroniser and the multiplexed display scan engine.
- Reads are combinational so the single-cycle core still sees load data in the same cycle.

Parameters:
- SCAN_DIV, 20000, clock cycles each display digit stays lit; legal range 2..2^20.
- DIG_NUM, 8, number of display digits; fixed at 8 in this revision.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous reset, active-low
- addr_i  in  32  byte address from the core ALU
- wr_data_i  in  32  store data from the core
- memwr_i  in  1  store strobe from the core
- rd_data_o  out  32  load data returned to the core
- dram_addr_o  out  32  address to data RAM, equal to addr_i
- dram_wdata_o  out  32  write data to data RAM, equal to wr_data_i
- dram_we_o  out  1  RAM write enable
- dram_rdata_i  in  32  RAM read data
- sw_i  in  24  asynchronous board switches
- led_o  out  24  LED drive, active-high
- dig_en_o  out  8  digit enables, active-low, one-hot
- seg_o  out  8  segments {a,b,c,d,e,f,g,dp}, active-low

Behaviour:
- Address map:
  - 0xFFFF_F000: DISP, read/write, 32-bit value, 8 hex nibbles.
  - 0xFFFF_F060: LED, read/write, bits [23:0].
  - 0xFFFF_F070: SW, read-only.
  - Any other address in 0xFFFF_F000..0xFFFF_FFFF is reserved.
  - All addresses below 0xFFFF_F000 are DRAM.
- Decode: full 32-bit compare, no aliasing.
- dram_we_o = memwr_i AND (DRAM selected). It is combinational, and it is 0 for every peripheral-page address, including reserved ones.
- rd_data_o, combinational:
  - DRAM: dram_rdata_i.
  - DISP: display register.
  - LED: {8'h0, led_reg}.
  - SW: {8'h0, sw_sync}.
  - Reserved: 32'h0.
- Register writes occur at posedge clk_i when memwr_i=1 and the address matches:
  - LED register takes wr_data_i[23:0].
  - DISP register takes all 32 bits.
  - Writes to SW or reserved addresses are ignored.
- A read of a register in the same cycle it is written returns the old value.
- Switch synchroniser: two flops. A change on sw_i is visible on rd_data_o after the 2nd rising edge.
- Scan engine:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - In the wrap cycle, dig_idx advances 0..7 and wraps 7 to 0.
  - dig_en_o and seg_o are registered from (dig_idx, DISP[4*dig_idx+3 : 4*dig_idx]), so they lag dig_idx by one cycle.
  - Digit 0 shows nibble [3:0]; digit 7 shows nibble [31:28].
- Display register update while scanning: the new value appears on the next clock for the currently lit digit. No blanking and no restart of the scan.
- Segment codes, active-low: 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09, A=11, b=C1, C=63, d=85, E=61, F=71. dp is always off (bit0=1).
- Reset (rst_i=0, asynchronous, effective immediately):
  - led_reg=0, disp_reg=0, sw_sync=0.
  - scan_cnt=0, dig_idx=0.
  - dig_en_o=8'hFE, seg_o=8'h03.
- Reset asserted mid-scan forces the values above at once. After release, digit 0 holds for a full SCAN_DIV cycles.
- Outputs during reset:
  - led_o=0.
  - dram_we_o still follows memwr_i decode.
  - rd_data_o still follows decode, returning register reset values.

Decomposition:
- Shared package io_pkg holds:
  - address constants ADDR_DISP, ADDR_LED, ADDR_SW, PERIPH_BASE=0xFFFF_F000;
  - the 16-entry segment code table as a function seg_code(nibble).
- One sub-module, seg_scan:
  - owns scan_cnt, dig_idx and the registered dig_en_o/seg_o;
  - inputs: clk_i, rst_i, 32-bit display value;
  - parameter: SCAN_DIV.
- io_bridge keeps the decode, the read mux, the LED/DISP registers and the synchroniser.

Test Plan:
- Reset: hold rst_i=0 for 3 cycles, release → led_o=0, dig_en_o=FE, seg_o=03, read of 0xFFFF_F060 returns 0.
- LED write: store 0x00A5_5A5A to 0xFFFF_F060 → after the edge, led_o=A55A5A and a read returns 0x00A55A5A; dram_we_o=0 during the store.
- Switch sync: sw_i changes 0 to 0x123456 at cycle N → a read of 0xFFFF_F070 returns 0 through edge N+1 and 0x00123456 from edge N+2.
- Scan, SCAN_DIV=4: write DISP=0x8765_4321 → dig_en_o cycles FE,FD,FB,...,7F every 4 cycles, and seg_o shows 9F,25,0D,99,49,41,1F,01 in that order, then wraps to FE/9F.
- DRAM passthrough: store 0xDEADBEEF to 0x0000_0010 → dram_we_o=1, dram_addr_o=0x10, dram_wdata_o=DEADBEEF; a load returns dram_rdata_i. A store to reserved 0xFFFF_F100 → dram_we_o=0, no register changes, read returns 0.
- Reset mid-scan: with dig_idx=5, pulse rst_i low between clock edges → dig_en_o=FE, seg_o=03 immediately (no clock needed), and disp_reg is cleared.

Source files
------------

// File: rtl/io_pkg.sv
// Shared address map and seven-segment code table for the memory-mapped I/O bridge.
package io_pkg;

  localparam logic [31:0] PERIPH_BASE = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_DISP   = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_LED    = 32'hFFFF_F060;
  localparam logic [31:0] ADDR_SW     = 32'hFFFF_F070;

  // Active-low {a,b,c,d,e,f,g,dp}; dp is always off.
  function automatic logic [7:0] seg_code(input logic [3:0] nibble);
    logic [7:0] code;
    case (nibble)
      4'h0: code = 8'h03;
      4'h1: code = 8'h9F;
      4'h2: code = 8'h25;
      4'h3: code = 8'h0D;
      4'h4: code = 8'h99;
      4'h5: code = 8'h49;
      4'h6: code = 8'h41;
      4'h7: code = 8'h1F;
      4'h8: code = 8'h01;
      4'h9: code = 8'h09;
      4'hA: code = 8'h11;
      4'hB: code = 8'hC1;
      4'hC: code = 8'h63;
      4'hD: code = 8'h85;
      4'hE: code = 8'h61;
      default: code = 8'h71;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg_scan.sv
// Multiplexed seven-segment scan: each digit stays lit for SCAN_DIV cycles,
// and the enables and segments are registered from the current digit index.
module seg_scan
  import io_pkg::*;
#(
  parameter int SCAN_DIV = 20000,
  parameter int DIG_NUM  = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] disp_i,
  output logic [7:0]  dig_en_o,
  output logic [7:0]  seg_o
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(DIG_NUM);

  logic [CW-1:0] scan_cnt;
  logic [IW-1:0] dig_idx;
  logic          scan_wrap;
  logic [3:0]    cur_nibble;

  assign scan_wrap  = (scan_cnt == CW'(SCAN_DIV - 1));
  assign cur_nibble = disp_i[{dig_idx, 2'b00} +: 4];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      if (scan_wrap)
        dig_idx <= (dig_idx == IW'(DIG_NUM - 1)) ? '0 : dig_idx + 1'b1;
    end
  end

  // One cycle behind dig_idx; a display update shows on the next clock.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      dig_en_o <= 8'hFE;
      seg_o    <= 8'h03;
    end else begin
      dig_en_o <= ~(8'h01 << dig_idx);
      seg_o    <= seg_code(cur_nibble);
    end
  end

endmodule

// File: rtl/io_bridge.sv
// Memory-mapped I/O bridge: decodes core data accesses to RAM or to the
// LED / switch / display peripheral page; load data is combinational.
module io_bridge
  import io_pkg::*;
#(
  parameter int SCAN_DIV = 20000,
  parameter int DIG_NUM  = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wr_data_i,
  input  logic        memwr_i,
  output logic [31:0] rd_data_o,
  output logic [31:0] dram_addr_o,
  output logic [31:0] dram_wdata_o,
  output logic        dram_we_o,
  input  logic [31:0] dram_rdata_i,
  input  logic [23:0] sw_i,
  output logic [23:0] led_o,
  output logic [7:0]  dig_en_o,
  output logic [7:0]  seg_o
);

  logic        sel_dram, sel_disp, sel_led, sel_sw;
  logic [23:0] led_reg;
  logic [31:0] disp_reg;
  logic [23:0] sw_meta, sw_sync;

  // Full 32-bit compare: nothing in the peripheral page aliases.
  assign sel_dram = (addr_i < PERIPH_BASE);
  assign sel_disp = (addr_i == ADDR_DISP);
  assign sel_led  = (addr_i == ADDR_LED);
  assign sel_sw   = (addr_i == ADDR_SW);

  assign dram_addr_o  = addr_i;
  assign dram_wdata_o = wr_data_i;
  assign dram_we_o    = memwr_i & sel_dram;
  assign led_o        = led_reg;

  always_comb begin
    rd_data_o = 32'h0;
    if (sel_dram)      rd_data_o = dram_rdata_i;
    else if (sel_disp) rd_data_o = disp_reg;
    else if (sel_led)  rd_data_o = {8'h0, led_reg};
    else if (sel_sw)   rd_data_o = {8'h0, sw_sync};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      led_reg  <= '0;
      disp_reg <= '0;
    end else if (memwr_i) begin
      if (sel_led)  led_reg  <= wr_data_i[23:0];
      if (sel_disp) disp_reg <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_i;
      sw_sync <= sw_meta;
    end
  end

  seg_scan #(
    .SCAN_DIV (SCAN_DIV),
    .DIG_NUM  (DIG_NUM)
  ) u_seg_scan (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .disp_i   (disp_reg),
    .dig_en_o (dig_en_o),
    .seg_o    (seg_o)
  );

endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge: directed cases followed by random accesses,
// compared against a cycle-counting reference model.
module tb_io_bridge;

  localparam int DIV = 4;
  localparam logic [31:0] BASE = 32'hFFFF_F000;
  localparam logic [31:0] DISP = 32'hFFFF_F000;
  localparam logic [31:0] LED  = 32'hFFFF_F060;
  localparam logic [31:0] SW   = 32'hFFFF_F070;

  // clock / reset
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic [31:0] addr_i = '0, wr_data_i = '0, dram_rdata_i = '0;
  logic        memwr_i = 1'b0;
  logic [23:0] sw_i = '0;
  logic [31:0] rd_data_o, dram_addr_o, dram_wdata_o;
  logic        dram_we_o;
  logic [23:0] led_o;
  logic [7:0]  dig_en_o, seg_o;

  io_bridge #(.SCAN_DIV(DIV), .DIG_NUM(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .wr_data_i(wr_data_i),
    .memwr_i(memwr_i), .rd_data_o(rd_data_o), .dram_addr_o(dram_addr_o),
    .dram_wdata_o(dram_wdata_o), .dram_we_o(dram_we_o), .dram_rdata_i(dram_rdata_i),
    .sw_i(sw_i), .led_o(led_o), .dig_en_o(dig_en_o), .seg_o(seg_o)
  );

  int errs = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  bit          mon_en = 1'b0;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // reference model: digit lit after edge k is (k / DIV) mod 8, edges counted from reset release
  logic [7:0]  seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
  logic [31:0] m_disp = '0;
  logic [23:0] m_led = '0, m_sw1 = '0, m_sw2 = '0;
  int          m_edges = 0;
  logic [7:0]  m_dig_en = 8'hFE, m_seg = 8'h03;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_disp = '0; m_led = '0; m_sw1 = '0; m_sw2 = '0; m_edges = 0;
      m_dig_en = 8'hFE; m_seg = 8'h03;
    end else begin
      int d;
      logic [3:0] nib;
      d = (m_edges / DIV) % 8;
      nib = m_disp[4*d +: 4];
      m_dig_en = ~(8'h01 << d);
      m_seg = seg_tab[nib];
      m_edges++;
      m_sw2 = m_sw1;
      m_sw1 = sw_i;
      if (memwr_i && addr_i == LED)  m_led  = wr_data_i[23:0];
      if (memwr_i && addr_i == DISP) m_disp = wr_data_i;
    end
  end

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (a < BASE)   return dram_rdata_i;
    if (a == DISP)  return m_disp;
    if (a == LED)   return {8'h0, m_led};
    if (a == SW)    return {8'h0, m_sw2};
    return 32'h0;
  endfunction

  // scoreboard monitor
  always @(negedge clk_i) begin
    if (mon_en) begin
      check("dig_en", {24'h0, dig_en_o}, {24'h0, m_dig_en});
      check("seg", {24'h0, seg_o}, {24'h0, m_seg});
      check("led", {8'h0, led_o}, {8'h0, m_led});
      check("dram_we", {31'h0, dram_we_o}, {31'h0, memwr_i && (addr_i < BASE)});
      check("dram_addr", dram_addr_o, addr_i);
      check("dram_wdata", dram_wdata_o, wr_data_i);
      if (exp_q.size() > 0) begin
        logic [31:0] e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, rd_data_o, e);
      end
    end
  end

  // driver: one access per cycle, inputs changed just after the rising edge
  task automatic op(input logic [31:0] a, input logic [31:0] wd, input logic we,
                    input logic [23:0] sw, input logic [31:0] rdat, input string n);
    @(posedge clk_i);
    #1;
    addr_i = a; wr_data_i = wd; memwr_i = we; sw_i = sw; dram_rdata_i = rdat;
    exp_q.push_back(model_rd(a));
    name_q.push_back(n);
  endtask

  initial begin
    int guard;
    #1 rst_i = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    check("rst_dig_en", {24'h0, dig_en_o}, 32'hFE);
    check("rst_seg", {24'h0, seg_o}, 32'h03);
    check("rst_led", {8'h0, led_o}, 32'h0);
    op(LED, 32'h0, 1'b0, 24'h0, 32'h0, "rst_rd_led");
    #1 check("rst_rd_led_d", rd_data_o, 32'h0);

    // LED store; same-cycle read sees the old value
    op(LED, 32'h00A5_5A5A, 1'b1, 24'h0, 32'h0, "led_wr_old");
    #1 check("led_wr_we", {31'h0, dram_we_o}, 32'h0);
    op(LED, 32'h0, 1'b0, 24'h0, 32'h0, "led_rd");
    #1 check("led_rd_d", rd_data_o, 32'h00A5_5A5A);
    check("led_o_d", {8'h0, led_o}, 32'h00A5_5A5A);

    // switch synchroniser latency
    op(SW, 32'h0, 1'b0, 24'h123456, 32'h0, "sw0");
    #1 check("sw_lag0", rd_data_o, 32'h0);
    op(SW, 32'h0, 1'b0, 24'h123456, 32'h0, "sw1");
    #1 check("sw_lag1", rd_data_o, 32'h0);
    op(SW, 32'h0, 1'b0, 24'h123456, 32'h0, "sw2");
    #1 check("sw_lag2", rd_data_o, 32'h0012_3456);

    // scan through all eight digits and wrap
    op(DISP, 32'h8765_4321, 1'b1, 24'h123456, 32'h0, "disp_wr");
    for (int i = 0; i < 8 * DIV + 12; i++)
      op(DISP, 32'h0, 1'b0, 24'h123456, 32'h0, "disp_rd");

    // DRAM passthrough and reserved-address store
    op(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 24'h123456, 32'h1357_9BDF, "dram_st");
    #1 check("dram_st_we", {31'h0, dram_we_o}, 32'h1);
    check("dram_st_addr", dram_addr_o, 32'h10);
    check("dram_st_wd", dram_wdata_o, 32'hDEAD_BEEF);
    op(32'h0000_0010, 32'h0, 1'b0, 24'h123456, 32'hCAFE_F00D, "dram_ld");
    #1 check("dram_ld_d", rd_data_o, 32'hCAFE_F00D);
    op(32'hFFFF_F100, 32'hFFFF_FFFF, 1'b1, 24'h123456, 32'h0, "resv_st");
    #1 check("resv_we", {31'h0, dram_we_o}, 32'h0);
    check("resv_rd", rd_data_o, 32'h0);
    op(LED, 32'h0, 1'b0, 24'h123456, 32'h0, "resv_led_kept");
    op(DISP, 32'h0, 1'b0, 24'h123456, 32'h0, "resv_disp_kept");

    // asynchronous reset while digit 5 is being scanned
    guard = 0;
    while (((m_edges / DIV) % 8) != 5 && guard < 200) begin
      op(DISP, 32'h0, 1'b0, 24'h123456, 32'h0, "wait_rd");
      guard++;
    end
    check("wait_dig5", guard < 200 ? 32'h1 : 32'h0, 32'h1);
    @(posedge clk_i);
    #1 addr_i = DISP; memwr_i = 1'b0;
    #1 rst_i = 1'b0;
    #1;
    check("mid_rst_dig_en", {24'h0, dig_en_o}, 32'hFE);
    check("mid_rst_seg", {24'h0, seg_o}, 32'h03);
    check("mid_rst_disp", rd_data_o, 32'h0);
    #1 rst_i = 1'b1;
    for (int i = 0; i < DIV + 4; i++)
      op(DISP, 32'h0, 1'b0, 24'h123456, 32'h0, "post_rst");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [23:0] sw;
      case ($urandom_range(0, 4))
        0: a = DISP;
        1: a = LED;
        2: a = SW;
        3: a = BASE + ($urandom_range(1, 1023) << 2);
        default: a = $urandom & 32'h7FFF_FFFF;
      endcase
      sw = ($urandom_range(0, 7) == 0) ? 24'($urandom) : sw_i;
      op(a, $urandom, 1'($urandom_range(0, 1)), sw, $urandom, "rand_rd");
    end

    @(posedge clk_i);
    #1 memwr_i = 1'b0;
    @(negedge clk_i);
    #1 check("queue_drained", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
